// File: rtl/cpu_sequencer.sv
// Program loader and run supervisor for a small CPU core.
// Streams a program into memory, releases the CPU, and stops it on halt or timeout.
module cpu_sequencer #(
    parameter int ADDR_LENGTH = 11,
    parameter int INSTRUCTION_LENGTH = 16,
    parameter int OPCODE_LENGTH = 5,
    parameter logic [OPCODE_LENGTH-1:0] HALT_OPCODE = '0,
    parameter int MAX_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          load_valid,
    input  logic [INSTRUCTION_LENGTH-1:0] load_data,
    input  logic                          load_last,
    output logic                          load_ready,
    output logic                          pm_we,
    output logic [ADDR_LENGTH-1:0]        pm_addr,
    output logic [INSTRUCTION_LENGTH-1:0] pm_wdata,
    output logic                          cpu_reset,
    input  logic [OPCODE_LENGTH-1:0]      cpu_opcode,
    input  logic [ADDR_LENGTH-1:0]        cpu_pc,
    output logic                          busy,
    output logic                          halted,
    output logic                          timeout,
    output logic                          overflow,
    output logic [31:0]                   cycle_count,
    output logic [ADDR_LENGTH-1:0]        final_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [31:0] CYC_LIMIT = 32'(MAX_CYCLES - 1);
    localparam logic [ADDR_LENGTH-1:0] PTR_MAX = '1;

    state_t                 state_q, state_d;
    logic [ADDR_LENGTH-1:0] ptr_q, ptr_d;
    logic                   timeout_q, timeout_d;
    logic                   overflow_q, overflow_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [ADDR_LENGTH-1:0] fpc_q, fpc_d;
    logic                   accept;

    assign load_ready  = (state_q == S_LOAD);
    assign accept      = load_ready && load_valid;
    assign pm_we       = accept;
    assign pm_addr     = ptr_q;
    assign pm_wdata    = accept ? load_data : '0;
    assign cpu_reset   = (state_q == S_RUN);
    assign busy        = (state_q == S_LOAD) || (state_q == S_ARM)
                      || (state_q == S_RUN);
    assign halted      = (state_q == S_DONE);
    assign timeout     = timeout_q;
    assign overflow    = overflow_q;
    assign cycle_count = cnt_q;
    assign final_pc    = fpc_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q;
        cnt_d      = cnt_q;
        fpc_d      = fpc_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (ptr_q != PTR_MAX) begin
                        ptr_d = ptr_q + 1'b1;
                    end
                    if (load_last) begin
                        state_d = S_ARM;
                    end else if (ptr_q == PTR_MAX) begin
                        state_d    = S_ARM;
                        overflow_d = 1'b1;
                    end
                end
            end
            S_ARM: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 32'd1;
                end
                // halt takes priority over the cycle limit
                if (cpu_opcode == HALT_OPCODE) begin
                    state_d = S_DONE;
                    fpc_d   = cpu_pc;
                end else if (cnt_q == CYC_LIMIT) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    fpc_d     = cpu_pc;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    ptr_d      = '0;
                    timeout_d  = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
            fpc_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
            fpc_q      <= fpc_d;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: vector table, directed corner sequences,
// and random traffic against a behavioural model of two configurations.
module tb_cpu_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        load_valid;
    logic        load_last;
    logic [15:0] load_data;
    logic [4:0]  cpu_opcode;
    logic [10:0] cpu_pc;

    logic        load_ready_a, pm_we_a, cpu_reset_a, busy_a, halted_a;
    logic        timeout_a, overflow_a;
    logic [10:0] pm_addr_a, final_pc_a;
    logic [15:0] pm_wdata_a;
    logic [31:0] cycle_count_a;

    logic        load_ready_b, pm_we_b, cpu_reset_b, busy_b, halted_b;
    logic        timeout_b, overflow_b;
    logic [2:0]  pm_addr_b, final_pc_b;
    logic [15:0] pm_wdata_b;
    logic [31:0] cycle_count_b;

    int checks = 0;
    int errors = 0;

    cpu_sequencer u_a (
        .clk(clk), .reset(rst_n), .start(start),
        .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready_a),
        .pm_we(pm_we_a), .pm_addr(pm_addr_a), .pm_wdata(pm_wdata_a),
        .cpu_reset(cpu_reset_a), .cpu_opcode(cpu_opcode),
        .cpu_pc(cpu_pc), .busy(busy_a), .halted(halted_a),
        .timeout(timeout_a), .overflow(overflow_a),
        .cycle_count(cycle_count_a), .final_pc(final_pc_a)
    );

    cpu_sequencer #(.ADDR_LENGTH(3), .MAX_CYCLES(8)) u_b (
        .clk(clk), .reset(rst_n), .start(start),
        .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready_b),
        .pm_we(pm_we_b), .pm_addr(pm_addr_b), .pm_wdata(pm_wdata_b),
        .cpu_reset(cpu_reset_b), .cpu_opcode(cpu_opcode),
        .cpu_pc(cpu_pc[2:0]), .busy(busy_b), .halted(halted_b),
        .timeout(timeout_b), .overflow(overflow_b),
        .cycle_count(cycle_count_b), .final_pc(final_pc_b)
    );

    task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start = 0; load_valid = 0; load_last = 0;
        load_data = '0; cpu_opcode = 5'd1; cpu_pc = '0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    // start, one-word program, ARM; returns at the top of RUN cycle 1
    task automatic go_run();
        start = 1;
        tick();
        start = 0; load_valid = 1; load_last = 1; load_data = 16'h1234;
        tick();
        load_valid = 0; load_last = 0;
        tick();
    endtask

    function automatic logic [75:0] pack(
        logic lr, logic we, logic [10:0] ad, logic [15:0] wd,
        logic cr, logic bs, logic hl, logic t, logic o,
        logic [31:0] c, logic [10:0] f);
        return {lr, we, ad, wd, cr, bs, hl, t, o, c, f};
    endfunction

    // Reference model: phase 0 idle, 1 load, 2 arm, 3 run, 4 done
    int     ph[2], ptr[2], fpc[2];
    longint cnt[2];
    bit     to[2], ov[2];
    int     depth[2] = '{2048, 8};
    int     mx[2] = '{65535, 8};

    function automatic void m_reset();
        for (int k = 0; k < 2; k++) begin
            ph[k] = 0; ptr[k] = 0; fpc[k] = 0;
            cnt[k] = 0; to[k] = 0; ov[k] = 0;
        end
    endfunction

    function automatic void m_step();
        for (int k = 0; k < 2; k++) begin
            bit full;
            bit lim;
            full = (ptr[k] == depth[k] - 1);
            lim = (cnt[k] == mx[k] - 1);
            case (ph[k])
                0: if (start) begin ph[k] = 1; ptr[k] = 0; end
                1: if (load_valid) begin
                    if (load_last || full) ph[k] = 2;
                    if (full && !load_last) ov[k] = 1;
                    if (!full) ptr[k]++;
                end
                2: begin cnt[k] = 0; ph[k] = 3; end
                3: begin
                    if (cnt[k] < 64'hFFFF_FFFF) cnt[k]++;
                    if (cpu_opcode == 5'd0) begin
                        ph[k] = 4; fpc[k] = int'(cpu_pc) % depth[k];
                    end else if (lim) begin
                        ph[k] = 4; to[k] = 1;
                        fpc[k] = int'(cpu_pc) % depth[k];
                    end
                end
                4: if (start) begin
                    ph[k] = 1; ptr[k] = 0; to[k] = 0; ov[k] = 0;
                end
                default: ph[k] = 0;
            endcase
        end
    endfunction

    task automatic cmp_model();
        for (int k = 0; k < 2; k++) begin
            logic [75:0] e, a;
            logic we;
            we = (ph[k] == 1) && load_valid;
            e = pack(ph[k] == 1, we, we ? 11'(ptr[k]) : 11'd0,
                     we ? load_data : 16'd0, ph[k] == 3,
                     ph[k] >= 1 && ph[k] <= 3, ph[k] == 4, to[k], ov[k],
                     32'(cnt[k]), 11'(fpc[k]));
            if (k == 0)
                a = pack(load_ready_a, pm_we_a, we ? pm_addr_a : 11'd0,
                         pm_wdata_a, cpu_reset_a, busy_a, halted_a,
                         timeout_a, overflow_a, cycle_count_a, final_pc_a);
            else
                a = pack(load_ready_b, pm_we_b,
                         we ? {8'd0, pm_addr_b} : 11'd0, pm_wdata_b,
                         cpu_reset_b, busy_b, halted_b, timeout_b,
                         overflow_b, cycle_count_b, {8'd0, final_pc_b});
            chk(k == 0 ? "model_a" : "model_b", 80'(a), 80'(e));
        end
    endtask

    typedef struct {
        bit st; bit lv; bit last;
        logic [15:0] d; logic [4:0] op; logic [10:0] pc;
        bit lr; bit we; logic [10:0] addr; bit cr; bit bs; bit hl;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int n;
        //          st lv ls data      op    pc    lr we addr  cr bs hl
        tbl[0]  = '{1, 0, 0, 16'h0000, 5'd1, 11'd0, 0, 0, 11'd0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 16'hA001, 5'd1, 11'd0, 1, 1, 11'd0, 0, 1, 0};
        tbl[2]  = '{0, 1, 0, 16'hB002, 5'd1, 11'd0, 1, 1, 11'd1, 0, 1, 0};
        tbl[3]  = '{0, 1, 1, 16'hC003, 5'd1, 11'd0, 1, 1, 11'd2, 0, 1, 0};
        tbl[4]  = '{0, 0, 0, 16'h0000, 5'd1, 11'd0, 0, 0, 11'd0, 0, 1, 0};
        tbl[5]  = '{0, 0, 0, 16'h0000, 5'd1, 11'd0, 0, 0, 11'd0, 1, 1, 0};
        tbl[6]  = '{0, 0, 0, 16'h0000, 5'd0, 11'd5, 0, 0, 11'd0, 1, 1, 0};
        tbl[7]  = '{1, 0, 0, 16'h0000, 5'd1, 11'd0, 0, 0, 11'd0, 0, 0, 1};
        tbl[8]  = '{0, 1, 0, 16'hD004, 5'd1, 11'd0, 1, 1, 11'd0, 0, 1, 0};
        tbl[9]  = '{1, 0, 0, 16'hEEEE, 5'd1, 11'd0, 1, 0, 11'd0, 0, 1, 0};
        tbl[10] = '{0, 1, 0, 16'hE005, 5'd1, 11'd0, 1, 1, 11'd1, 0, 1, 0};
        tbl[11] = '{0, 0, 0, 16'h0000, 5'd1, 11'd0, 1, 0, 11'd0, 0, 1, 0};
        tbl[12] = '{0, 1, 1, 16'hF006, 5'd1, 11'd0, 1, 1, 11'd2, 0, 1, 0};
        tbl[13] = '{1, 0, 0, 16'h0000, 5'd1, 11'd0, 0, 0, 11'd0, 0, 1, 0};
        tbl[14] = '{1, 0, 0, 16'h0000, 5'd1, 11'd0, 0, 0, 11'd0, 1, 1, 0};

        idle_in();
        rst_n = 0;
        tick();
        tick();
        chk("reset_a", 80'(pack(load_ready_a, pm_we_a, pm_addr_a,
            pm_wdata_a, cpu_reset_a, busy_a, halted_a, timeout_a,
            overflow_a, cycle_count_a, final_pc_a)), 80'd0);
        chk("reset_b", 80'(pack(load_ready_b, pm_we_b, {8'd0, pm_addr_b},
            pm_wdata_b, cpu_reset_b, busy_b, halted_b, timeout_b,
            overflow_b, cycle_count_b, {8'd0, final_pc_b})), 80'd0);
        rst_n = 1;
        tick();

        for (int i = 0; i < 15; i++) begin
            start = tbl[i].st; load_valid = tbl[i].lv;
            load_last = tbl[i].last; load_data = tbl[i].d;
            cpu_opcode = tbl[i].op; cpu_pc = tbl[i].pc;
            #1;
            chk($sformatf("vec%0d", i),
                80'({load_ready_a, pm_we_a,
                     tbl[i].we ? pm_addr_a : 11'd0, pm_wdata_a,
                     cpu_reset_a, busy_a, halted_a}),
                80'({tbl[i].lr, tbl[i].we, tbl[i].addr,
                     tbl[i].we ? tbl[i].d : 16'd0,
                     tbl[i].cr, tbl[i].bs, tbl[i].hl}));
            tick();
        end

        // halt on the 10th run cycle
        do_reset();
        go_run();
        chk("run_cnt0", 80'(cycle_count_a), 80'd0);
        chk("run_crst", 80'(cpu_reset_a), 80'd1);
        for (int c = 1; c <= 10; c++) begin
            cpu_opcode = (c == 10) ? 5'd0 : 5'd7;
            cpu_pc = 11'(c - 1);
            tick();
        end
        cpu_opcode = 5'd1;
        chk("halt_done", 80'(halted_a), 80'd1);
        chk("halt_cnt", 80'(cycle_count_a), 80'd10);
        chk("halt_fpc", 80'(final_pc_a), 80'd9);
        chk("halt_crst_to", 80'({cpu_reset_a, timeout_a}), 80'd0);
        tick();
        chk("done_hold", 80'({halted_a, cycle_count_a}), 80'({1'b1, 32'd10}));

        // cycle-limit timeout, then halt exactly on the limit cycle
        do_reset();
        go_run();
        cpu_opcode = 5'd3; cpu_pc = 11'd3;
        n = 0;
        while (!halted_b && n < 20) begin
            tick();
            n++;
        end
        chk("to_cycles", 80'(n), 80'd8);
        chk("to_flag", 80'(timeout_b), 80'd1);
        chk("to_cnt", 80'(cycle_count_b), 80'd8);
        chk("to_fpc", 80'(final_pc_b), 80'd3);
        start = 1;
        tick();
        start = 0;
        chk("to_clear", 80'({timeout_b, load_ready_b}), 80'({1'b0, 1'b1}));
        load_valid = 1; load_last = 1;
        tick();
        load_valid = 0; load_last = 0;
        tick();
        for (int c = 1; c <= 8; c++) begin
            cpu_opcode = (c == 8) ? 5'd0 : 5'd2;
            tick();
        end
        cpu_opcode = 5'd1;
        chk("lim_halt", 80'({halted_b, timeout_b}), 80'({1'b1, 1'b0}));
        chk("lim_cnt", 80'(cycle_count_b), 80'd8);

        // overflow on an 8-deep memory
        do_reset();
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 8; i++) begin
            load_valid = 1; load_last = 0; load_data = 16'(16'h5A00 + i);
            #1;
            chk($sformatf("ovf_wr%0d", i),
                80'({pm_we_b, pm_addr_b, pm_wdata_b}),
                80'({1'b1, 3'(i), 16'(16'h5A00 + i)}));
            tick();
        end
        load_valid = 0;
        #1;
        chk("ovf_flag", 80'({overflow_b, overflow_a}), 80'({1'b1, 1'b0}));
        chk("ovf_arm", 80'({busy_b, load_ready_b, cpu_reset_b, pm_we_b}),
            80'(4'b1000));
        tick();
        chk("ovf_run", 80'(cpu_reset_b), 80'd1);

        // reset in the middle of a run, then a fresh session
        do_reset();
        go_run();
        cpu_opcode = 5'd4;
        repeat (5) tick();
        chk("mid_pre", 80'(cycle_count_a), 80'd5);
        rst_n = 0;
        #1;
        chk("mid_rst", 80'(pack(load_ready_a, pm_we_a, pm_addr_a,
            pm_wdata_a, cpu_reset_a, busy_a, halted_a, timeout_a,
            overflow_a, cycle_count_a, final_pc_a)), 80'd0);
        tick();
        tick();
        rst_n = 1;
        tick();
        chk("mid_idle", 80'({busy_a, halted_a}), 80'd0);
        go_run();
        chk("fresh_cnt0", 80'(cycle_count_a), 80'd0);
        for (int c = 1; c <= 3; c++) begin
            cpu_opcode = (c == 3) ? 5'd0 : 5'd9;
            cpu_pc = 11'(40 + c);
            tick();
        end
        cpu_opcode = 5'd1;
        chk("fresh_done", 80'({halted_a, cycle_count_a, final_pc_a}),
            80'({1'b1, 32'd3, 11'd43}));

        // random traffic against the model
        do_reset();
        m_reset();
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            load_valid = 1'($urandom_range(0, 1));
            load_last = ($urandom_range(0, 3) == 0);
            load_data = 16'($urandom);
            cpu_opcode = ($urandom_range(0, 9) == 0) ? 5'd0
                       : 5'($urandom_range(1, 31));
            cpu_pc = 11'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
            if (!rst_n) m_reset();
            #1;
            cmp_model();
            @(posedge clk);
            if (rst_n) m_step();
            else m_reset();
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter ADDR_LENGTH, default 11: program-memory address width.
REQ-002 Parameter INSTRUCTION_LENGTH, default 16: load word width.
REQ-003 Parameter OPCODE_LENGTH, default 5: opcode width.
REQ-004 Parameter HALT_OPCODE, default 5'b00000: opcode that ends a run.
REQ-005 Parameter MAX_CYCLES, default 65535: run-cycle limit before timeout.
REQ-006 clk  input  1  sole clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  one-cycle pulse; begins a load-and-run session.
REQ-009 load_valid  input  1  load_data holds a valid instruction word.
REQ-010 load_data  input  INSTRUCTION_LENGTH  instruction word to write.
REQ-011 load_last  input  1  qualifies the final word of the program.
REQ-012 load_ready  output  1  sequencer accepts a word this cycle.
REQ-013 pm_we  output  1  program-memory write strobe.
REQ-014 pm_addr  output  ADDR_LENGTH  program-memory write address.
REQ-015 pm_wdata  output  INSTRUCTION_LENGTH  program-memory write data.
REQ-016 cpu_reset  output  1  active-low reset driven to the CPU.
REQ-017 cpu_opcode  input  OPCODE_LENGTH  opcode of the instruction currently fetched by the CPU.
REQ-018 cpu_pc  input  ADDR_LENGTH  CPU program-memory address.
REQ-019 busy  output  1  high in LOAD, ARM, RUN.
REQ-020 halted  output  1  high in DONE.
REQ-021 timeout  output  1  sticky; run ended by cycle limit.
REQ-022 overflow  output  1  sticky; load exceeded memory depth.
REQ-023 cycle_count  output  32  CPU cycles executed in last/current run.
REQ-024 final_pc  output  ADDR_LENGTH  cpu_pc captured at run end.

Function
REQ-025 FSM states IDLE, LOAD, ARM, RUN, DONE; encoding free.
REQ-026 IDLE: cpu_reset=0, load_ready=0; start -> LOAD; other inputs ignored.
REQ-027 LOAD: load_ready=1; word accepted when load_valid&&load_ready.
REQ-028 On accept, pm_we=1 combinationally that cycle, pm_wdata=load_data, pm_addr=write pointer; pointer increments after accept.
REQ-029 Write pointer cleared to 0 on entry to LOAD.
REQ-030 Accept with load_last=1 -> ARM next cycle.
REQ-031 Accept at pointer 2^ADDR_LENGTH-1 with load_last=0: word written, overflow=1, -> ARM; pointer does not wrap.
REQ-032 ARM: exactly one cycle, cpu_reset=0, cycle_count cleared to 0 -> RUN.
REQ-033 RUN: cpu_reset=1; cycle_count increments by 1 every cycle spent in RUN.
REQ-034 RUN: cpu_opcode==HALT_OPCODE -> DONE next cycle; final_pc<=cpu_pc same edge.
REQ-035 RUN: cycle_count==MAX_CYCLES-1 and no halt -> DONE, timeout=1, final_pc captured.
REQ-036 Halt and limit in same cycle: halt wins, timeout stays 0.
REQ-037 DONE: cpu_reset=0 (CPU frozen), halted=1, cycle_count and final_pc hold.
REQ-038 DONE: start -> LOAD; timeout and overflow clear on that transition.
REQ-039 start ignored in LOAD, ARM, RUN (no restart mid-session).
REQ-040 cycle_count saturates at 2^32-1; never wraps.

Reset
REQ-041 reset low asynchronously forces IDLE, cpu_reset=0, load_ready=0, pm_we=0, pm_addr=0, pm_wdata=0, busy=0, halted=0, timeout=0, overflow=0, cycle_count=0, final_pc=0.
REQ-042 reset asserted mid-LOAD or mid-RUN aborts the session; no partial-state retention; exit to IDLE on first clk edge after reset high.

Verification
REQ-043 Load 3 words (A,B,C; last on C), load_valid held high -> pm_we 3 cycles at addrs 0,1,2; ARM 1 cycle; cpu_reset rises cycle after.
REQ-044 load_valid toggled 1,0,1,0,1 -> only 3 pm_we pulses, addresses contiguous 0..2.
REQ-045 RUN, cpu_opcode=HALT_OPCODE on 10th RUN cycle with cpu_pc=9 -> DONE, cycle_count=10, final_pc=9, cpu_reset=0, timeout=0.
REQ-046 MAX_CYCLES=8, no halt -> DONE after 8 RUN cycles, timeout=1, cycle_count=8; halt on cycle 8 instead -> timeout=0.
REQ-047 ADDR_LENGTH=3, 8 words no load_last -> overflow=1, last write addr 7, ARM entered.
REQ-048 reset pulsed low 5 cycles into RUN -> all outputs at REQ-041 values immediately; start afterwards runs a fresh session with counters from 0.
